cp0_reg_file: RTL

//  Coprocessor-0 register file: responder for the MTC0/MFC0 requests decoded in ID. Holds BadVAddr, Count,

---
 rtl/cp0_reg_file_pkg.sv | 71 +++++++
 rtl/cp0_reg_file_timer.sv | 62 ++++++
 rtl/cp0_reg_file.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cp0_reg_file_pkg.sv
// Shared CP0 definitions: register addresses, Status/Cause field layout,
// write masks, ExcCode constants and packing helpers.
package cp0_reg_file_pkg;

  // Address is {rd[4:0], sel[2:0]}; every mapped register uses sel 0.
  typedef enum logic [7:0] {
    CP0_BADVADDR = 8'h40,
    CP0_COUNT    = 8'h48,
    CP0_COMPARE  = 8'h58,
    CP0_STATUS   = 8'h60,
    CP0_CAUSE    = 8'h68,
    CP0_EPC      = 8'h70,
    CP0_PRID     = 8'h78
  } cp0_addr_e;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int STATUS_BEV = 22;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef struct packed {
    logic [7:0] im;
    logic       exl;
    logic       ie;
  } status_t;

  // ip[7:2] mirror IP[15:10] (sampled lines), ip[1:0] are the software bits IP[9:8].
  typedef struct packed {
    logic       bd;
    logic [7:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

  function automatic logic [31:0] status_word(input status_t s);
    logic [31:0] w;
    w             = '0;
    w[STATUS_BEV] = 1'b1;
    w[15:8]       = s.im;
    w[STATUS_EXL] = s.exl;
    w[STATUS_IE]  = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] cause_word(input cause_t c, input logic ti);
    logic [31:0] w;
    w           = '0;
    w[CAUSE_BD] = c.bd;
    w[CAUSE_TI] = ti;
    w[15:8]     = c.ip;
    w[6:2]      = c.exc_code;
    return w;
  endfunction

endpackage

// File: rtl/cp0_reg_file_timer.sv
// Count/Compare timer: prescaled Count, Compare match and the TI flag.
module cp0_reg_file_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] write_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti,
  output logic        ti_next
);

  localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [31:0]      count_reg, count_next;
  logic [31:0]      compare_reg, compare_next;
  logic             ti_reg;

  always_comb begin
    div_next     = div_reg;
    count_next   = count_reg;
    compare_next = compare_reg;
    if (count_we) begin
      count_next = write_data;
      div_next   = '0;
    end else if (div_reg == DIV_LAST) begin
      div_next   = '0;
      count_next = count_reg + 32'd1;
    end else begin
      div_next = div_reg + DIV_W'(1);
    end
    if (compare_we) begin
      compare_next = write_data;
    end
    // Match uses post-update values; a Compare write always clears TI.
    ti_next = compare_we ? 1'b0 : (ti_reg | (count_next == compare_next));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg     <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      ti_reg      <= 1'b0;
    end else begin
      div_reg     <= div_next;
      count_reg   <= count_next;
      compare_reg <= compare_next;
      ti_reg      <= ti_next;
    end
  end

  assign count   = count_reg;
  assign compare = compare_reg;
  assign ti      = ti_reg;

endmodule

// File: rtl/cp0_reg_file.sv
// CP0 register file: MTC0/MFC0 responder, exception/ERET bookkeeping,
// interrupt-pending generation and pipeline redirect PC.
module cp0_reg_file
  import cp0_reg_file_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
  parameter int          COUNT_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cp0_write_en,
  input  logic        cp0_read_en,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] cp0_write_data,
  output logic [31:0] cp0_read_data,
  input  logic [5:0]  hw_int,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret,
  output logic        int_pending,
  output logic [31:0] redirect_pc,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] count, compare;
  logic        ti, ti_next;

  status_t     status_reg, status_next;
  cause_t      cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] badvaddr_reg, badvaddr_next;
  logic        int_pending_reg, int_pending_next;
  logic        mtc0_ok;

  // An exception or ERET in the same cycle swallows the MTC0 entirely.
  assign mtc0_ok = cp0_write_en & ~exc_valid & ~eret;

  cp0_reg_file_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0_ok && (cp0_addr == CP0_COUNT)),
    .compare_we (mtc0_ok && (cp0_addr == CP0_COMPARE)),
    .write_data (cp0_write_data),
    .count      (count),
    .compare    (compare),
    .ti         (ti),
    .ti_next    (ti_next)
  );

  always_comb begin
    status_next   = status_reg;
    cause_next    = cause_reg;
    epc_next      = epc_reg;
    badvaddr_next = badvaddr_reg;

    if (exc_valid) begin
      cause_next.exc_code = exc_code;
      status_next.exl     = 1'b1;
      // Nested exceptions keep the original return point.
      if (!status_reg.exl) begin
        epc_next      = exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
        cause_next.bd = exc_in_delay;
      end
      if (is_addr_exc(exc_code)) begin
        badvaddr_next = exc_badvaddr;
      end
    end else if (eret) begin
      status_next.exl = 1'b0;
    end else if (mtc0_ok) begin
      case (cp0_addr)
        CP0_STATUS: status_next = '{im:  cp0_write_data[15:8],
                                    exl: cp0_write_data[STATUS_EXL],
                                    ie:  cp0_write_data[STATUS_IE]};
        CP0_CAUSE:  cause_next.ip[1:0] = cp0_write_data[9:8];
        CP0_EPC:    epc_next = cp0_write_data;
        default:    ;
      endcase
    end

    cause_next.ip[7:2] = {hw_int[5] | ti_next, hw_int[4:0]};
    int_pending_next   = status_next.ie & ~status_next.exl
                         & (|(cause_next.ip & status_next.im));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_reg      <= '0;
      cause_reg       <= '0;
      epc_reg         <= '0;
      badvaddr_reg    <= '0;
      int_pending_reg <= 1'b0;
    end else begin
      status_reg      <= status_next;
      cause_reg       <= cause_next;
      epc_reg         <= epc_next;
      badvaddr_reg    <= badvaddr_next;
      int_pending_reg <= int_pending_next;
    end
  end

  always_comb begin
    cp0_read_data = '0;
    if (cp0_read_en) begin
      case (cp0_addr)
        CP0_BADVADDR: cp0_read_data = badvaddr_reg;
        CP0_COUNT:    cp0_read_data = count;
        CP0_COMPARE:  cp0_read_data = compare;
        CP0_STATUS:   cp0_read_data = status_word(status_reg);
        CP0_CAUSE:    cp0_read_data = cause_word(cause_reg, ti);
        CP0_EPC:      cp0_read_data = epc_reg;
        CP0_PRID:     cp0_read_data = PRID_VALUE;
        default:      cp0_read_data = '0;
      endcase
    end
  end

  always_comb begin
    redirect_pc = '0;
    if (exc_valid) begin
      redirect_pc = EXC_VECTOR;
    end else if (eret) begin
      redirect_pc = epc_reg;
    end
  end

  assign status_o    = status_word(status_reg);
  assign cause_o     = cause_word(cause_reg, ti);
  assign epc_o       = epc_reg;
  assign int_pending = int_pending_reg;

endmodule
